alu_share_arb: RTL

- Shares the single 32-bit ALU datapath between NREQ independent requesters, for example the integer pipeline and a multi-cycle helper unit.
- Requests are granted round-robin. The block captures the winner's operands, drives them to the external ALU for one cycle, registers ALUResult/Zero, and returns a tagged response over a valid/ready handshake.
- The block sits beside the ALU instance. It owns the ALU's SrcA/SrcB/ALUControl inputs whenever it is instantiated.

---
 rtl/alu_arb_pkg.sv | 23 ++
 rtl/rr_grant.sv | 30 +++
 rtl/alu_share_arb.sv | 115 +++++++++++
 3 files changed

// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared types, ALU op codes and op legality check for alu_share_arb
package alu_arb_pkg;

  localparam int ALU_CTRL_W = 3;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  function automatic logic is_legal_op(input logic [ALU_CTRL_W-1:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_AND) ||
           (op == ALU_OR)  || (op == ALU_SLT);
  endfunction

endpackage

// File: rtl/rr_grant.sv
// rtl/rr_grant.sv - combinational round-robin picker: first asserted req at or above ptr, wrapping
module rr_grant #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - round-robin sharing of one ALU between NREQ requesters, tagged response
// Optional illegal-opcode trapping: define ALU_SHARE_ARB_OPCHECK_EN.
module alu_share_arb
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*32-1:0]         req_srca,
  input  logic [NREQ*32-1:0]         req_srcb,
  input  logic [NREQ*ALU_CTRL_W-1:0] req_op,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [IDW-1:0]             rsp_id,
  output logic [31:0]                rsp_result,
  output logic                       rsp_zero,
  output logic                       rsp_err,
  output logic [31:0]                alu_srca,
  output logic [31:0]                alu_srcb,
  output logic [ALU_CTRL_W-1:0]      alu_ctrl,
  input  logic [31:0]                alu_result,
  input  logic                       alu_zero
);

  arb_state_t state, state_nxt;

  logic [IDW-1:0]        ptr, cap_id, gnt_idx;
  logic [NREQ-1:0]       gnt;
  logic                  gnt_any, accept;
  logic [31:0]           cap_a, cap_b, sel_a, sel_b;
  logic [ALU_CTRL_W-1:0] cap_op, sel_op;
  logic                  cap_err, sel_err;

  rr_grant #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  assign req_ready = (state == IDLE && !reset) ? gnt : '0;
  assign accept    = (state == IDLE) && gnt_any;

  assign sel_a  = req_srca[int'(gnt_idx)*32 +: 32];
  assign sel_b  = req_srcb[int'(gnt_idx)*32 +: 32];
`ifdef ALU_SHARE_ARB_OPCHECK_EN
  // Illegal ops reach the ALU as ADD; the response is overridden in EXEC.
  assign sel_err = !is_legal_op(req_op[int'(gnt_idx)*ALU_CTRL_W +: ALU_CTRL_W]);
  assign sel_op  = sel_err ? ALU_ADD : req_op[int'(gnt_idx)*ALU_CTRL_W +: ALU_CTRL_W];
`else
  assign sel_err = 1'b0;
  assign sel_op  = req_op[int'(gnt_idx)*ALU_CTRL_W +: ALU_CTRL_W];
`endif

  assign alu_srca = cap_a;
  assign alu_srcb = cap_b;
  assign alu_ctrl = cap_op;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_any) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr     <= '0;
      cap_id  <= '0;
      cap_a   <= '0;
      cap_b   <= '0;
      cap_op  <= '0;
      cap_err <= 1'b0;
    end else if (accept) begin
      ptr     <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      cap_id  <= gnt_idx;
      cap_a   <= sel_a;
      cap_b   <= sel_b;
      cap_op  <= sel_op;
      cap_err <= sel_err;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else if (state == EXEC) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= cap_id;
      rsp_result <= cap_err ? 32'd0 : alu_result;
      rsp_zero   <= cap_err | alu_zero;
      rsp_err    <= cap_err;
    end else if (state == RESP && rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule
